// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with synchronous flush and an occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  entry_t mem [DEPTH];
  ptr_t   rd_ptr;
  ptr_t   wr_ptr;
  logic   full;
  logic   do_push;
  logic   do_pop;

  assign empty = (count == '0);
  assign full  = (count == cnt_t'(DEPTH));
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push & (!full | pop);
  assign do_pop  = pop & !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, one-deep in-flight tracking, issue throttling
// against the prefetch queue, and the decode-side valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int               FQ_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  output logic [XLEN-1:0]             o_imem_addr,
  output logic                        o_imem_req,
  input  logic [31:0]                 i_imem_rdata,
  input  logic                        i_redirect,
  input  logic [XLEN-1:0]             i_redirect_pc,
  output logic                        o_instr_valid,
  output logic [31:0]                 o_instr,
  output logic [XLEN-1:0]             o_instr_pc,
  output logic [XLEN-1:0]             o_instr_pc4,
  input  logic                        i_instr_ready,
  output logic [$clog2(FQ_DEPTH):0]   o_fq_count,
  output logic [XLEN-1:0]             o_pc_debug
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef logic [CW:0] occ_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  entry_t          head;
  entry_t          wdata;
  logic [CW-1:0]   count;
  logic            empty;
  logic            deq;
  logic            issue;
  occ_t            occ;

  // Handshake: the head transfers on a rising edge where o_instr_valid and i_instr_ready
  // are both high; while valid is high and ready low the head fields do not change.
  assign o_instr_valid = !empty;
  assign deq           = o_instr_valid & i_instr_ready;

  // Occupancy after this edge, counting the word already in flight.
  assign occ   = occ_t'(count) + occ_t'(inflight) - occ_t'(deq);
  assign issue = !i_reset & !i_redirect & (occ < occ_t'(FQ_DEPTH));

  assign o_imem_req  = issue;
  assign o_imem_addr = fetch_pc;
  assign o_pc_debug  = fetch_pc;
  assign o_fq_count  = count;

  assign wdata.instr = i_imem_rdata;
  assign wdata.pc    = inflight_pc;

  assign o_instr     = o_instr_valid ? head.instr : NOP_INSTR;
  assign o_instr_pc  = head.pc;
  assign o_instr_pc4 = head.pc + XLEN'(4);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (i_redirect) begin
      fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .flush (i_redirect),
    .push  (inflight),
    .wdata (wdata),
    .pop   (deq),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized ready/redirect run checked
// against a sequential-PC reference model of the instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        ready;
  logic [2:0]  fq_count;
  logic [31:0] pc_debug;

  logic [31:0] addr_w;
  logic        req_w;
  logic [31:0] rdata_w;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic [31:0] pc4_w;
  logic        ready_w = 1'b1;
  logic [2:0]  count_w;
  logic [31:0] pcdbg_w;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .o_imem_addr(imem_addr), .o_imem_req(imem_req),
    .i_imem_rdata(imem_rdata), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .o_instr_pc4(instr_pc4), .i_instr_ready(ready), .o_fq_count(fq_count),
    .o_pc_debug(pc_debug)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) dut_w (
    .i_clk(clk), .i_reset(rst), .o_imem_addr(addr_w), .o_imem_req(req_w),
    .i_imem_rdata(rdata_w), .i_redirect(redirect_w), .i_redirect_pc(redirect_pc_w),
    .o_instr_valid(valid_w), .o_instr(instr_w), .o_instr_pc(pc_w),
    .o_instr_pc4(pc4_w), .i_instr_ready(ready_w), .o_fq_count(count_w),
    .o_pc_debug(pcdbg_w)
  );

  // Instruction memory image: word[i] = 0x1000 + i, synchronous read.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    imem_rdata <= word_at(imem_addr);
    rdata_w    <= word_at(addr_w);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = rdy;
    #1;
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_count", fq_count, 3'd0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_pc", pc_debug, 32'h0);
    check_eq("rst_instr_nop", instr, 32'h0000_0013);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic        post_redir;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          n_acc;

    // Stream from reset with ready held high.
    do_reset(1'b1);
    #1;
    check_eq("t1_req0", imem_req, 1'b1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    step();
    check_eq("t1_valid_e1", instr_valid, 1'b0);
    check_eq("t1_pc_e1", pc_debug, 32'h4);
    step();
    check_eq("t1_valid_e2", instr_valid, 1'b1);
    check_eq("t1_pc_e2", instr_pc, 32'h0);
    check_eq("t1_pc4_e2", instr_pc4, 32'h4);
    check_eq("t1_instr_e2", instr, 32'h1000);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq("t1_stream_valid", instr_valid, 1'b1);
      check_eq("t1_stream_pc", instr_pc, 32'(k * 4));
      check_eq("t1_stream_instr", instr, word_at(32'(k * 4)));
    end

    // Stall until the queue fills, then drain in order.
    do_reset(1'b0);
    repeat (10) step();
    check_eq("t2_count_full", fq_count, 3'd4);
    check_eq("t2_req_full", imem_req, 1'b0);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    check_eq("t2_head_valid", instr_valid, 1'b1);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
    ready = 1'b1;
    #1;
    check_eq("t2_req_on_deq", imem_req, 1'b1);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check_eq("t2_drain_valid", instr_valid, 1'b1);
      check_eq("t2_drain_pc", instr_pc, e);
      check_eq("t2_drain_instr", instr, word_at(e));
      step();
    end

    // Redirect from a full queue with ready high in the same cycle.
    do_reset(1'b0);
    repeat (8) step();
    check_eq("t3_count_full", fq_count, 3'd4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    ready       = 1'b1;
    #1;
    check_eq("t3_req_in_redirect", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    check_eq("t3_count_after", fq_count, 3'd0);
    check_eq("t3_valid_after", instr_valid, 1'b0);
    check_eq("t3_fetch_pc", pc_debug, 32'h200);
    step();
    check_eq("t3_valid_r1", instr_valid, 1'b0);
    step();
    check_eq("t3_valid_r2", instr_valid, 1'b1);
    check_eq("t3_pc_r2", instr_pc, 32'h200);
    check_eq("t3_instr_r2", instr, 32'h1080);

    // Redirect while the first request is in flight.
    do_reset(1'b1);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    check_eq("t4_count", fq_count, 3'd0);
    step();
    check_eq("t4_valid_e3", instr_valid, 1'b0);
    step();
    check_eq("t4_valid_e4", instr_valid, 1'b1);
    check_eq("t4_pc_e4", instr_pc, 32'h40);

    // Asynchronous reset between edges.
    do_reset(1'b1);
    repeat (5) step();
    check_eq("t5_streaming", instr_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_valid", instr_valid, 1'b0);
    check_eq("t5_async_count", fq_count, 3'd0);
    check_eq("t5_async_req", imem_req, 1'b0);
    check_eq("t5_async_pc", pc_debug, 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    check_eq("t5_restart_valid", instr_valid, 1'b1);
    check_eq("t5_restart_pc", instr_pc, 32'h0);

    // PC wrap on the second instance.
    do_reset(1'b1);
    step();
    step();
    check_eq("t6_valid", valid_w, 1'b1);
    check_eq("t6_pc0", pc_w, 32'hFFFF_FFF8);
    check_eq("t6_pc4_0", pc4_w, 32'hFFFF_FFFC);
    step();
    check_eq("t6_pc1", pc_w, 32'hFFFF_FFFC);
    check_eq("t6_pc4_1", pc4_w, 32'h0);
    step();
    check_eq("t6_pc2", pc_w, 32'h0);
    check_eq("t6_pc4_2", pc4_w, 32'h4);
    check_eq("t6_instr2", instr_w, 32'h1000);

    // Randomized ready/redirect against the sequential-stream model.
    do_reset(1'b1);
    exp_pc     = 32'h0;
    prev_hold  = 1'b0;
    post_redir = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    n_acc      = 0;
    for (int c = 0; c < 400; c++) begin
      ready       = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      #1;
      check_eq("rnd_count_bound", 32'(fq_count <= 3'd4), 32'd1);
      if (prev_hold) begin
        check_eq("rnd_hold_valid", instr_valid, 1'b1);
        check_eq("rnd_hold_pc", instr_pc, prev_pc);
        check_eq("rnd_hold_instr", instr, prev_instr);
      end
      if (post_redir) begin
        check_eq("rnd_redir_count", fq_count, 3'd0);
        check_eq("rnd_redir_valid", instr_valid, 1'b0);
      end
      if (redirect) begin
        check_eq("rnd_redir_req", imem_req, 1'b0);
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (instr_valid && ready) begin
        check_eq("rnd_pc", instr_pc, exp_pc);
        check_eq("rnd_instr", instr, word_at(exp_pc));
        check_eq("rnd_pc4", instr_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      prev_hold  = instr_valid & !ready & !redirect;
      prev_pc    = instr_pc;
      prev_instr = instr;
      post_redir = redirect;
      step();
    end
    redirect = 1'b0;
    check_eq("rnd_progress", 32'(n_acc > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) core; replaces the bare pc_reg / pc+4 adder / pc_mux path of the single-cycle design.
- Owns the fetch PC, issues requests to a synchronous-read instruction memory and buffers returned instructions in a prefetch queue.
- Hands instructions to decode with a valid/ready handshake; an execute-stage redirect flushes everything in flight.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FQ_DEPTH, 4, prefetch queue entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- o_imem_addr  out  XLEN  fetch address, equals fetch PC.
- o_imem_req  out  1  request this cycle.
- i_imem_rdata  in  32  instruction, valid the cycle after the request.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  XLEN  restart target.
- o_instr_valid  out  1  queue head is valid.
- o_instr  out  32  head instruction.
- o_instr_pc  out  XLEN  head PC.
- o_instr_pc4  out  XLEN  head PC+4, for JAL/JALR write-back.
- i_instr_ready  in  1  decode accepts the head.
- o_fq_count  out  $clog2(FQ_DEPTH)+1  queue occupancy.
- o_pc_debug  out  XLEN  current fetch PC.

Behaviour:
- Reset (asynchronous, active-high; applies mid-operation too):
  - fetch PC = RESET_PC.
  - Queue empty; in-flight flag cleared.
  - o_instr_valid = 0, o_fq_count = 0, o_imem_req = 0 while reset is asserted.
- Cycle numbering: edge N is the Nth rising edge after reset is released.
- Dequeue: deq = o_instr_valid & i_instr_ready.
- Issue:
  - o_imem_req = !i_redirect & ((count + inflight − deq) < FQ_DEPTH). This is a combinational path from i_instr_ready to o_imem_req.
  - On issue: inflight <= 1, inflight_pc <= fetch PC, fetch PC <= fetch PC + 4 (modulo 2^XLEN; wraps silently).
- Return:
  - If inflight is set, the next edge writes {i_imem_rdata, inflight_pc} into the queue.
  - inflight clears unless a new issue happens in the same cycle.
- Latency: request at edge N → o_instr_valid at edge N+2.
  - First instruction is valid after edge 2 following reset release.
  - Sustained 1 instruction/cycle while ready is held high.
- Empty queue: o_instr_valid = 0, o_instr = 32'h0000_0013 (NOP), o_instr_pc and o_instr_pc4 are don't-care.
- Full queue: no issue unless the same cycle dequeues. Simultaneous enqueue and dequeue when full is legal; count stays the same.
- Redirect (highest priority):
  - At the edge: queue cleared, inflight cleared (returning data discarded), fetch PC <= {i_redirect_pc[XLEN-1:2], 2'b00}.
  - No request in the redirect cycle. A dequeue in the same cycle is ignored; the head is discarded and o_fq_count becomes 0.
  - The first instruction from the target is valid 2 cycles after the redirect edge.
  - Back-to-back redirects: the last one wins.
- o_fq_count counts valid queue entries only, not in-flight data.
- Handshake rule: o_instr, o_instr_pc and o_instr_pc4 are stable while o_instr_valid = 1 and ready = 0.

Decomposition:
- fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Packed struct fq_entry_t {instr, pc}.
  - Default RESET_PC.
- Sub-module fetch_fifo:
  - Synchronous FIFO, parametrised DEPTH and entry type.
  - Synchronous flush, push/pop/count.
  - Pointers wrap modulo DEPTH; the extra count bit distinguishes full from empty.
- fetch_unit holds the PC, in-flight tracking and the issue logic.

Test Plan:
- Reset release, ready = 1, imem holds word[i] = 0x1000+i → requests at 0x0, 0x4, 0x8…; valid from edge 2; head pc 0x0 → pc4 0x4; one instruction per cycle, in order.
- Ready = 0 for 10 cycles, FQ_DEPTH = 4 → o_fq_count saturates at 4, o_imem_req = 0, head stays pc 0x0; ready = 1 → pcs 0x0–0xC drain in order with no gap or duplicate.
- Full queue, redirect to 0x0000_0203 with ready = 1 in the same cycle → next cycle count = 0, valid = 0; fetch PC 0x200; valid instruction pc 0x200 two cycles later.
- Redirect while a request is in flight → returning word discarded, never presented.
- Reset asserted mid-stream between edges → o_instr_valid and count drop immediately (asynchronously); fetch restarts at RESET_PC.
- RESET_PC = 0xFFFF_FFF8, stream → pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); pc4 of the last = 0x0000_0004.
